// File: rtl/wb_arbiter_pkg.sv
// Shared constants and the writeback entry type used by the arbiter and its lane buffers.
package wb_arbiter_pkg;

    localparam int FU_NUM    = 4;
    localparam int EPOCH_W   = 2;
    localparam int PHYS_REGS = 64;
    localparam int PHYS_W    = $clog2(PHYS_REGS);
    localparam int DW        = 32;

    // One buffered FU result.
    typedef struct packed {
        logic [PHYS_W-1:0]  pd;
        logic [DW-1:0]      data;
        logic [EPOCH_W-1:0] epoch;
    } wb_entry_t;

endpackage

// File: rtl/wb_lane_buf.sv
// Single FU lane buffer: DEPTH-entry in-order shift queue (entry 0 oldest)
// with push, pop, and flush compaction that keeps only entries of the
// surviving epoch. Reports how many entries the flush discarded.
module wb_lane_buf
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    input  wb_entry_t          push_entry,
    input  logic               pop,
    input  logic               flush_valid,
    input  logic [EPOCH_W-1:0] flush_epoch,
    output wb_entry_t          head,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   count_next,
    output logic               ready,
    output logic [CNT_W-1:0]   drop_num
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    wb_entry_t        entries_q [DEPTH];
    wb_entry_t        entries_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] keep;
    logic [CNT_W-1:0] slot;
    logic             accept;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign ready      = (count_q < DEPTH_C);
    assign accept     = push_valid && ready;
    assign head       = entries_q[0];
    assign count      = count_q;
    assign count_next = count_d;

    // Next queue contents: flush compaction, or shift-on-pop followed by push.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        drop_num  = '0;
        keep      = '0;
        slot      = count_q;
        if (flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < count_q) begin
                    if (entries_q[i].epoch == flush_epoch) begin
                        for (int j = 0; j < DEPTH; j++) begin
                            if (CNT_W'(j) == keep) entries_d[j] = entries_q[i];
                        end
                        keep = keep + ONE_C;
                    end else begin
                        drop_num = drop_num + ONE_C;
                    end
                end
            end
            // A push racing the flush completes its handshake but is discarded if stale.
            if (accept) begin
                if (push_entry.epoch == flush_epoch) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (CNT_W'(j) == keep) entries_d[j] = push_entry;
                    end
                    keep = keep + ONE_C;
                end else begin
                    drop_num = drop_num + ONE_C;
                end
            end
            count_d = keep;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i + 1];
                slot = count_q - ONE_C;
            end
            if (accept) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (CNT_W'(j) == slot) entries_d[j] = push_entry;
                end
            end
            count_d = slot + CNT_W'(accept);
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '{default: '0};
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from FU_NUM lanes and serialises them
// onto the single PRF writeback port through a round-robin grant and a
// registered output stage. Flush drops buffered results of stale epochs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PEND_W = $clog2(FU_NUM * DEPTH + 1),
    localparam int PTR_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FU_NUM-1:0]               in_valid,
    output logic [FU_NUM-1:0]               in_ready,
    input  logic [FU_NUM-1:0][PHYS_W-1:0]   in_pd,
    input  logic [FU_NUM-1:0][DW-1:0]       in_data,
    input  logic [FU_NUM-1:0][EPOCH_W-1:0]  in_epoch,
    input  logic                            flush_valid,
    input  logic [EPOCH_W-1:0]              flush_epoch,
    output logic                            wb_valid,
    output logic [PHYS_W-1:0]               wb_pd,
    output logic [DW-1:0]                   wb_data,
    output logic [EPOCH_W-1:0]              wb_epoch,
    output logic [PEND_W-1:0]               pending,
    output logic [15:0]                     drop_cnt
);

    wb_entry_t        lane_in   [FU_NUM];
    wb_entry_t        lane_head [FU_NUM];
    logic [CNT_W-1:0] lane_cnt  [FU_NUM];
    logic [CNT_W-1:0] lane_nxt  [FU_NUM];
    logic [CNT_W-1:0] lane_drop [FU_NUM];
    logic [FU_NUM-1:0] lane_pop;

    logic              gnt_found;
    logic              grant;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wb_valid_q, wb_valid_d;
    wb_entry_t         wb_entry_q, wb_entry_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum;

    for (genvar g = 0; g < FU_NUM; g++) begin : g_lane
        assign lane_in[g] = {in_pd[g], in_data[g], in_epoch[g]};

        wb_lane_buf #(.DEPTH(DEPTH)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .push_valid (in_valid[g]),
            .push_entry (lane_in[g]),
            .pop        (lane_pop[g]),
            .flush_valid(flush_valid),
            .flush_epoch(flush_epoch),
            .head       (lane_head[g]),
            .count      (lane_cnt[g]),
            .count_next (lane_nxt[g]),
            .ready      (in_ready[g]),
            .drop_num   (lane_drop[g])
        );
    end

    // Round-robin pick of the first non-empty lane starting at rr_ptr; no grant during flush.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            if (!gnt_found && (lane_cnt[(int'(rr_ptr_q) + k) % FU_NUM] != '0)) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'((int'(rr_ptr_q) + k) % FU_NUM);
            end
        end
        grant = gnt_found && !flush_valid;
        for (int i = 0; i < FU_NUM; i++) begin
            lane_pop[i] = grant && (gnt_idx == PTR_W'(i));
        end
    end

    // Next output stage, pointer and counters.
    always_comb begin
        wb_valid_d = grant;
        wb_entry_d = grant ? lane_head[gnt_idx] : wb_entry_q;
        rr_ptr_d   = grant ? PTR_W'((int'(gnt_idx) + 1) % FU_NUM) : rr_ptr_q;
        pending_d  = '0;
        drop_sum   = {1'b0, drop_cnt_q};
        for (int i = 0; i < FU_NUM; i++) begin
            pending_d = pending_d + PEND_W'(lane_nxt[i]);
            drop_sum  = drop_sum + 17'(lane_drop[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Registered writeback stage and bookkeeping state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_entry_q <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_entry_q <= wb_entry_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_pd    = wb_entry_q.pd;
    assign wb_data  = wb_entry_q.data;
    assign wb_epoch = wb_entry_q.epoch;
    assign pending  = pending_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

    localparam int NL    = 4;
    localparam int DEPTH = 2;
    localparam int PW    = 6;

    logic              clk;
    logic              rst;
    logic [NL-1:0]     in_valid;
    logic [NL-1:0]     in_ready;
    logic [NL-1:0][PW-1:0] in_pd;
    logic [NL-1:0][31:0]   in_data;
    logic [NL-1:0][1:0]    in_epoch;
    logic              flush_valid;
    logic [1:0]        flush_epoch;
    logic              wb_valid;
    logic [PW-1:0]     wb_pd;
    logic [31:0]       wb_data;
    logic [1:0]        wb_epoch;
    logic [3:0]        pending;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pd(in_pd), .in_data(in_data), .in_epoch(in_epoch),
        .flush_valid(flush_valid), .flush_epoch(flush_epoch),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_data(wb_data), .wb_epoch(wb_epoch),
        .pending(pending), .drop_cnt(drop_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one FIFO per lane holding {pd, data, epoch}
    logic [39:0] m_q [NL][$];
    int          m_rr;
    int          m_drop;
    logic        m_wb_valid;
    logic [39:0] m_wb;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_q[i].delete();
        m_rr = 0; m_drop = 0; m_wb_valid = 1'b0; m_wb = '0;
    endtask

    function automatic int m_pending();
        int s = 0;
        for (int i = 0; i < NL; i++) s += m_q[i].size();
        return s;
    endfunction

    // Apply one clock edge's worth of rules to the model using current inputs.
    task automatic model_step();
        logic [NL-1:0] acc;
        logic [39:0] e;
        int n, start, l;
        for (int i = 0; i < NL; i++) acc[i] = in_valid[i] && (m_q[i].size() < DEPTH);
        m_wb_valid = 1'b0;
        if (flush_valid) begin
            for (int i = 0; i < NL; i++) begin
                n = m_q[i].size();
                for (int k = 0; k < n; k++) begin
                    e = m_q[i].pop_front();
                    if (e[1:0] == flush_epoch) m_q[i].push_back(e);
                    else m_drop++;
                end
                if (acc[i]) begin
                    if (in_epoch[i] == flush_epoch) m_q[i].push_back({in_pd[i], in_data[i], in_epoch[i]});
                    else m_drop++;
                end
            end
        end else begin
            start = m_rr;
            for (int k = 0; k < NL; k++) begin
                l = (start + k) % NL;
                if (!m_wb_valid && m_q[l].size() > 0) begin
                    m_wb = m_q[l].pop_front();
                    m_wb_valid = 1'b1;
                    m_rr = (l + 1) % NL;
                end
            end
            for (int i = 0; i < NL; i++)
                if (acc[i]) m_q[i].push_back({in_pd[i], in_data[i], in_epoch[i]});
        end
        if (m_drop > 65535) m_drop = 65535;
    endtask

    // Driver tasks
    task automatic clear_inputs();
        in_valid = '0; in_pd = '0; in_data = '0; in_epoch = '0;
        flush_valid = 1'b0; flush_epoch = 2'd0;
    endtask

    task automatic drive_lane(input int l, input int pd, input logic [31:0] d, input int ep);
        in_valid[l] = 1'b1;
        in_pd[l]    = PW'(pd);
        in_data[l]  = d;
        in_epoch[l] = 2'(ep);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
        n_checks++; if ({wb_pd, wb_data, wb_epoch} !== 40'd0) begin n_fail++; $display("FAIL reset_wb_payload: got %h want 0", {wb_pd, wb_data, wb_epoch}); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'hF) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1111", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        drive_lane(0, 5, 32'hDEAD, 0);
        tick();
        clear_inputs();
        n_checks++; if (pending !== 4'd1) begin n_fail++; $display("FAIL single_pending1: got %0d want 1", pending); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0b want 0", wb_valid); end
        tick();
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid: got %0b want 1", wb_valid); end
        n_checks++; if (wb_pd !== 6'd5 || wb_data !== 32'hDEAD || wb_epoch !== 2'd0) begin n_fail++; $display("FAIL single_payload: got pd=%0d data=%h ep=%0d want pd=5 data=dead ep=0", wb_pd, wb_data, wb_epoch); end
        n_checks++; if (pending !== 4'd0) begin n_fail++; $display("FAIL single_pending0: got %0d want 0", pending); end
        tick();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %0b want 0", wb_valid); end
    endtask

    task automatic test_all_lanes();
        logic [31:0] d [NL];
        do_reset();
        for (int i = 0; i < NL; i++) begin
            d[i] = $urandom;
            drive_lane(i, 10 + i, d[i], 1);
        end
        tick();
        clear_inputs();
        for (int c = 0; c < NL; c++) begin
            tick();
            n_checks++;
            if (wb_valid !== 1'b1 || wb_pd !== PW'(10 + c) || wb_data !== d[c]) begin
                n_fail++; $display("FAIL all_lanes_order[%0d]: got v=%0b pd=%0d data=%h want v=1 pd=%0d data=%h", c, wb_valid, wb_pd, wb_data, 10 + c, d[c]);
            end
        end
        // rr_ptr should be back at lane 0: a lane 0/1 tie resolves to lane 0 first.
        drive_lane(1, 21, 32'h21, 1);
        drive_lane(0, 20, 32'h20, 1);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd20) begin n_fail++; $display("FAIL all_lanes_rr_wrap0: got v=%0b pd=%0d want v=1 pd=20", wb_valid, wb_pd); end
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd21) begin n_fail++; $display("FAIL all_lanes_rr_wrap1: got v=%0b pd=%0d want v=1 pd=21", wb_valid, wb_pd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_lane(2, 30, 32'hA, 0);
        tick();
        // A matching-epoch flush blocks the grant so the lane fills.
        drive_lane(2, 31, 32'hB, 0);
        flush_valid = 1'b1; flush_epoch = 2'd0;
        tick();
        flush_valid = 1'b0;
        n_checks++; if (in_ready[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_full_not_ready: got %0b want 0", in_ready[2]); end
        n_checks++; if (pending !== 4'd2) begin n_fail++; $display("FAIL b2b_pending_full: got %0d want 2", pending); end
        drive_lane(2, 32, 32'hC, 0);
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd30) begin n_fail++; $display("FAIL b2b_first: got v=%0b pd=%0d want v=1 pd=30", wb_valid, wb_pd); end
        n_checks++; if (pending !== 4'd1 || in_ready[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_cycle: got pending=%0d ready=%0b want pending=1 ready=1", pending, in_ready[2]); end
        tick();
        clear_inputs();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd31) begin n_fail++; $display("FAIL b2b_second: got v=%0b pd=%0d want v=1 pd=31", wb_valid, wb_pd); end
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd32 || wb_data !== 32'hC) begin n_fail++; $display("FAIL b2b_third: got v=%0b pd=%0d data=%h want v=1 pd=32 data=c", wb_valid, wb_pd, wb_data); end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || pending !== 4'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_drained: got v=%0b pending=%0d drop=%0d want 0 0 0", wb_valid, pending, drop_cnt); end
    endtask

    task automatic test_flush_epoch();
        do_reset();
        drive_lane(0, 40, 32'h40, 0);
        drive_lane(1, 41, 32'h41, 1);
        drive_lane(3, 43, 32'h43, 1);
        tick();
        clear_inputs();
        drive_lane(1, 42, 32'h42, 0);
        tick();
        clear_inputs();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd40) begin n_fail++; $display("FAIL flush_pre_grant: got v=%0b pd=%0d want v=1 pd=40", wb_valid, wb_pd); end
        flush_valid = 1'b1; flush_epoch = 2'd0;
        tick();
        clear_inputs();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_grant: got %0b want 0", wb_valid); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_drop_cnt: got %0d want 2", drop_cnt); end
        n_checks++; if (pending !== 4'd1) begin n_fail++; $display("FAIL flush_pending: got %0d want 1", pending); end
        tick();
        n_checks++; if (wb_valid !== 1'b1 || wb_pd !== 6'd42 || wb_epoch !== 2'd0) begin n_fail++; $display("FAIL flush_survivor: got v=%0b pd=%0d ep=%0d want v=1 pd=42 ep=0", wb_valid, wb_pd, wb_epoch); end
        tick();
        n_checks++; if (wb_valid !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL flush_drained: got v=%0b pending=%0d want 0 0", wb_valid, pending); end
    endtask

    task automatic test_flush_push();
        do_reset();
        drive_lane(0, 50, 32'h50, 2);
        flush_valid = 1'b1; flush_epoch = 2'd1;
        #1;
        n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_push_handshake: got %0b want 1", in_ready[0]); end
        tick();
        clear_inputs();
        n_checks++; if (drop_cnt !== 16'd1 || pending !== 4'd0) begin n_fail++; $display("FAIL flush_push_dropped: got drop=%0d pending=%0d want 1 0", drop_cnt, pending); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_never_wb[%0d]: got %0b want 0", c, wb_valid); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NL; i++) drive_lane(i, 60 + i, 32'(60 + i), 0);
        flush_valid = 1'b1; flush_epoch = 2'd0;
        tick();
        clear_inputs();
        drive_lane(0, 1, 32'h64, 0);
        flush_valid = 1'b1; flush_epoch = 2'd0;
        tick();
        clear_inputs();
        n_checks++; if (pending !== 4'd5) begin n_fail++; $display("FAIL rst_mid_prefill: got %0d want 5", pending); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (pending !== 4'd0 || wb_valid !== 1'b0 || in_ready !== 4'hF) begin n_fail++; $display("FAIL rst_mid_async: got pending=%0d v=%0b ready=%b want 0 0 1111", pending, wb_valid, in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (wb_valid !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL rst_mid_stale[%0d]: got v=%0b pending=%0d want 0 0", c, wb_valid, pending); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            in_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NL; i++) begin
                in_pd[i]    = PW'($urandom_range(0, 63));
                in_data[i]  = $urandom;
                in_epoch[i] = 2'($urandom_range(0, 2));
            end
            flush_valid = ($urandom_range(0, 9) == 0);
            flush_epoch = 2'($urandom_range(0, 2));
            tick();
            n_checks++; if (wb_valid !== m_wb_valid) begin n_fail++; $display("FAIL rand_wb_valid@%0d: got %0b want %0b", c, wb_valid, m_wb_valid); end
            if (m_wb_valid) begin
                n_checks++; if ({wb_pd, wb_data, wb_epoch} !== m_wb) begin n_fail++; $display("FAIL rand_payload@%0d: got %h want %h", c, {wb_pd, wb_data, wb_epoch}, m_wb); end
            end
            n_checks++; if (pending !== 4'(m_pending())) begin n_fail++; $display("FAIL rand_pending@%0d: got %0d want %0d", c, pending, m_pending()); end
            n_checks++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rand_drop_cnt@%0d: got %0d want %0d", c, drop_cnt, m_drop); end
            for (int i = 0; i < NL; i++) begin
                n_checks++; if (in_ready[i] !== (m_q[i].size() < DEPTH)) begin n_fail++; $display("FAIL rand_in_ready[%0d]@%0d: got %0b want %0b", i, c, in_ready[i], m_q[i].size() < DEPTH); end
            end
        end
        clear_inputs();
    endtask

    // Sequence and final report
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_all_lanes();
        test_back_to_back();
        test_flush_epoch();
        test_flush_push();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
